ula_ctrl: RTL
=============

// Module: ula_ctrl
// PURPOSE
//   Instruction sequencer for the 6-bit ALU (ula). Accepts one instruction over a valid/ready
//   handshake, reads operands from an internal register file and drives the ALU opcode/operands.
//   Writes the 8-bit ALU result back to the register file and reports it with status flags.
//   Sits between the input/keypad decoder (instruction source) and the display driver (result sink).
// PARAMETERS
//   NUM_REGS  8   register-file depth (power of 2)
//   ADDR_W    3   register index width, = $clog2(NUM_REGS)
//   REG_W     8   register width; equals the ALU result width
//   OPND_W    6   ALU operand width; operands are reg[OPND_W-1:0]
// PORTS
//   clk          in   1       single clock, rising edge
//   rst_n        in   1       asynchronous, active-low reset
//   instr_valid  in   1       instruction present on instr_* this cycle
//   instr_ready  out  1       controller can accept an instruction (high only in IDLE)
//   instr_op     in   3       opcode, see BEHAVIOUR
//   instr_rd     in   ADDR_W  destination register
//   instr_rs1    in   ADDR_W  source register -> ALU A
//   instr_rs2    in   ADDR_W  source register -> ALU B (ADD/SUB/MUL)
//   instr_imm    in   OPND_W  immediate -> ALU B (ADDI/SUBI) or load value (LOAD)
//   dbg_addr     in   ADDR_W  debug read index
//   dbg_data     out  REG_W   combinational read of reg[dbg_addr]
//   result       out  REG_W   last written-back value; holds until next writeback
//   result_valid out  1       one-cycle pulse in the cycle result updates
//   flag_neg     out  1       last SUB/SUBI had A < B (result wrapped)
//   flag_ovf     out  1       last MUL full product > 2**REG_W-1 (result truncated)
//   err          out  1       one-cycle pulse: reserved opcode rejected
// BEHAVIOUR
//   Opcodes: 000 LOAD, 001 ADD, 010 ADDI, 011 SUB, 100 SUBI, 101 MUL, 110 CLR, 111 reserved.
//   Reset (async, rst_n=0): state IDLE; all registers, result, flags 0; instr_ready 1;
//     result_valid 0; err 0. Reset mid-instruction aborts with no writeback.
//   Handshake: transfer when instr_valid & instr_ready; fields latched at that edge.
//     instr_valid while busy is ignored (no queuing); source must hold until accepted.
//   FSM: IDLE -> READ -> EXEC -> WB -> IDLE.
//     READ: latch A=reg[rs1][5:0], B=reg[rs2][5:0] or imm.
//     EXEC: drive ALU, register its output and flags.
//     WB:   reg[rd] <= result; result_valid=1.
//   Latency: accept at edge N; result_valid high during cycle N+3; instr_ready high again at N+3.
//     Max throughput one instruction per 4 cycles.
//   LOAD: reg[rd] <= zero-extended imm, bypasses ALU; same 4-cycle timing; flags unchanged.
//   CLR: all registers and flags <= 0 in WB; result <= 0; result_valid pulses.
//   Reserved 111: err pulses in READ cycle; back to IDLE; no writeback; flags unchanged.
//   Arithmetic: mod 2**REG_W, as the ALU computes. Operands zero-extended from 6 bits.
//   Flags: SUB/SUBI update flag_neg (set iff A<B) and clear flag_ovf;
//     MUL updates flag_ovf (set iff A*B > 255) and clears flag_neg;
//     ADD/ADDI clear both (6+6 bit sum never exceeds 8 bits).
//   Hazards: rd == rs1/rs2 is legal; operands read in READ, before WB.
//   dbg_data reflects the WB write from the following cycle.
// STRUCTURE
//   Shared package ula_pkg: opcode localparams (OP_LOAD..OP_CLR), state encoding
//     (IDLE, READ, EXEC, WB). The ALU module (ula) uses the same opcode constants.
//   Sub-modules: existing ula, instantiated unchanged; ula_regfile (NUM_REGS x REG_W,
//     two async read ports plus debug port, one sync write port, sync clear, async reset).
//   Flag logic stays in ula_ctrl.
// TESTING
//   Reset then LOAD r1<=5, LOAD r2<=3 -> each gives result_valid 3 cycles after accept,
//     result=5 then 3; dbg r1=5.
//   ADD r3=r1+r2 -> result=8, flags 0; SUB r4=r2-r1 -> result=8'hFE, flag_neg=1.
//   LOAD r5<=63; MUL r6=r5*r5 -> result=8'h81 (3969 mod 256), flag_ovf=1, flag_neg=0.
//   ADDI r1=r1+10 (rd==rs1) -> result=15; instr_valid held high throughout ->
//     only one accept per 4 cycles.
//   Op 111 -> err pulse, no result_valid, registers unchanged;
//     then CLR -> all dbg reads 0.
//   rst_n low during EXEC of MUL -> outputs and registers 0 at once, no result_valid,
//     instr_ready=1 after release.

Source files
------------

// File: rtl/ula_pkg.sv
// Shared constants and types for the ula sequencer slice:
// opcodes, FSM states and the latched instruction bundle.
package ula_pkg;

  localparam int NUM_REGS = 8;
  localparam int ADDR_W   = $clog2(NUM_REGS);
  localparam int REG_W    = 8;
  localparam int OPND_W   = 6;

  localparam logic [2:0] OP_LOAD = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_ADDI = 3'd2;
  localparam logic [2:0] OP_SUB  = 3'd3;
  localparam logic [2:0] OP_SUBI = 3'd4;
  localparam logic [2:0] OP_MUL  = 3'd5;
  localparam logic [2:0] OP_CLR  = 3'd6;
  localparam logic [2:0] OP_RSV  = 3'd7;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    EXEC,
    WB
  } state_t;

  typedef struct packed {
    logic [2:0]        op;
    logic [ADDR_W-1:0] rd;
    logic [ADDR_W-1:0] rs1;
    logic [ADDR_W-1:0] rs2;
    logic [OPND_W-1:0] imm;
  } instr_t;

  function automatic logic uses_imm(input logic [2:0] op);
    return (op == OP_ADDI) || (op == OP_SUBI) || (op == OP_LOAD);
  endfunction

endpackage

// File: rtl/ula.sv
// 6-bit ALU: add, subtract and multiply into an 8-bit result,
// plus raw compare / product-overflow indications.
module ula
  import ula_pkg::*;
(
  input  logic [2:0]        op,
  input  logic [OPND_W-1:0] a,
  input  logic [OPND_W-1:0] b,
  output logic [REG_W-1:0]  y,
  output logic              lt,
  output logic              big
);

  logic [2*OPND_W-1:0] prod;

  assign prod = a * b;
  assign lt   = a < b;
  assign big  = |prod[2*OPND_W-1:REG_W];

  always_comb begin
    y = '0;
    unique case (1'b1)
      (op == OP_ADD) || (op == OP_ADDI):
        y = REG_W'(a) + REG_W'(b);
      (op == OP_SUB) || (op == OP_SUBI):
        y = REG_W'(a) - REG_W'(b);
      (op == OP_MUL):
        y = prod[REG_W-1:0];
      default:
        y = '0;
    endcase
  end

endmodule

// File: rtl/ula_regfile.sv
// NUM_REGS x REG_W register file: two operand read ports,
// one debug read port, one write port and a bulk clear.
module ula_regfile
  import ula_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [REG_W-1:0]  wdata,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [OPND_W-1:0] rd1,
  output logic [OPND_W-1:0] rd2,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [REG_W-1:0]  dbg_data
);

  logic [REG_W-1:0] mem [NUM_REGS];

  // operand ports only carry what the ALU consumes
  assign rd1      = mem[ra1][OPND_W-1:0];
  assign rd2      = mem[ra2][OPND_W-1:0];
  assign dbg_data = mem[dbg_addr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

endmodule

// File: rtl/ula_ctrl.sv
// Instruction sequencer for ula: accept, read operands,
// execute, write back and report result with status flags.
module ula_ctrl
  import ula_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [2:0]        instr_op,
  input  logic [ADDR_W-1:0] instr_rd,
  input  logic [ADDR_W-1:0] instr_rs1,
  input  logic [ADDR_W-1:0] instr_rs2,
  input  logic [OPND_W-1:0] instr_imm,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [REG_W-1:0]  dbg_data,
  output logic [REG_W-1:0]  result,
  output logic              result_valid,
  output logic              flag_neg,
  output logic              flag_ovf,
  output logic              err
);

  state_t            state;
  instr_t            ins;
  logic [OPND_W-1:0] a, b;
  logic [OPND_W-1:0] rd1, rd2;
  logic [REG_W-1:0]  alu_y, res_q;
  logic              alu_lt, alu_big;
  logic              neg_q, ovf_q;
  logic              wb_we, wb_clr;

  assign wb_clr = (state == WB) && (ins.op == OP_CLR);
  assign wb_we  = (state == WB) && (ins.op != OP_CLR);

  ula u_ula (
    .op  (ins.op),
    .a   (a),
    .b   (b),
    .y   (alu_y),
    .lt  (alu_lt),
    .big (alu_big)
  );

  ula_regfile u_rf (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (wb_clr),
    .we       (wb_we),
    .waddr    (ins.rd),
    .wdata    (res_q),
    .ra1      (ins.rs1),
    .ra2      (ins.rs2),
    .rd1      (rd1),
    .rd2      (rd2),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      ins          <= '0;
      a            <= '0;
      b            <= '0;
      res_q        <= '0;
      neg_q        <= 1'b0;
      ovf_q        <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      flag_neg     <= 1'b0;
      flag_ovf     <= 1'b0;
      err          <= 1'b0;
      instr_ready  <= 1'b1;
    end else begin
      result_valid <= 1'b0;
      err          <= 1'b0;
      unique case (state)
        IDLE: begin
          if (instr_valid) begin
            ins.op      <= instr_op;
            ins.rd      <= instr_rd;
            ins.rs1     <= instr_rs1;
            ins.rs2     <= instr_rs2;
            ins.imm     <= instr_imm;
            err         <= (instr_op == OP_RSV);
            instr_ready <= 1'b0;
            state       <= READ;
          end
        end
        READ: begin
          if (ins.op == OP_RSV) begin
            instr_ready <= 1'b1;
            state       <= IDLE;
          end else begin
            a     <= rd1;
            b     <= uses_imm(ins.op) ? ins.imm : rd2;
            state <= EXEC;
          end
        end
        EXEC: begin
          // LOAD bypasses the ALU and keeps the current flags
          unique case (1'b1)
            (ins.op == OP_LOAD): begin
              res_q <= REG_W'(ins.imm);
              neg_q <= flag_neg;
              ovf_q <= flag_ovf;
            end
            (ins.op == OP_SUB) || (ins.op == OP_SUBI): begin
              res_q <= alu_y;
              neg_q <= alu_lt;
              ovf_q <= 1'b0;
            end
            (ins.op == OP_MUL): begin
              res_q <= alu_y;
              neg_q <= 1'b0;
              ovf_q <= alu_big;
            end
            default: begin
              res_q <= alu_y;
              neg_q <= 1'b0;
              ovf_q <= 1'b0;
            end
          endcase
          state <= WB;
        end
        WB: begin
          result       <= res_q;
          result_valid <= 1'b1;
          flag_neg     <= neg_q;
          flag_ovf     <= ovf_q;
          instr_ready  <= 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
